wb_master_bridge: RTL and testbench

Wishbone B4 classic single-cycle master that turns a simple valid/ready command stream into bus cycles toward slaves such as the register array. One command produces one READ or WRITE cycle, plus an optional READ-MODIFY-WRITE cycle when configured. The result comes back on a valid/ready response stream. A per-phase timeout counter protects against unresponsive slaves.

---
 rtl/wb_master_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_master_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic master: valid/ready command stream in, one bus cycle per command, valid/ready response out.
// Define WB_MASTER_RMW_EN to build the read-modify-write path (one CYC spanning read, GAP, write).
module wb_master_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int SEL_WIDTH     = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic                  cmd_rmw_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  we_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef WB_MASTER_RMW_EN
    typedef enum logic [1:0] {IDLE, PHASE, GAP, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, PHASE, RESP} state_t;
`endif

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [SEL_WIDTH-1:0] sel);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            m[i*GRANULE +: GRANULE] = {GRANULE{sel[i]}};
        end
        return m;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  stb_q, stb_d;
    logic                  cyc_q, cyc_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_to_q, rsp_to_d;
    logic [TW-1:0]         tmo_q, tmo_d;
`ifdef WB_MASTER_RMW_EN
    logic                  rmw_q, rmw_d;
    logic                  rd_phase_q, rd_phase_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [SEL_WIDTH-1:0]  wsel_q, wsel_d;
`else
    logic                  unused_rmw;
    assign unused_rmw = cmd_rmw_i;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        stb_d       = stb_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        tmo_d       = tmo_q;
`ifdef WB_MASTER_RMW_EN
        rmw_d       = rmw_q;
        rd_phase_d  = rd_phase_q;
        wdat_d      = wdat_q;
        wsel_d      = wsel_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    we_d    = cmd_we_i;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = PHASE;
`ifdef WB_MASTER_RMW_EN
                    rmw_d      = cmd_rmw_i;
                    rd_phase_d = cmd_rmw_i;
                    wdat_d     = cmd_dat_i;
                    wsel_d     = cmd_sel_i;
                    if (cmd_rmw_i) begin
                        we_d  = 1'b0;
                        sel_d = '1;
                    end
`endif
                end
            end
            PHASE: begin
                if (err_i) begin
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b0;
                    state_d     = RESP;
                end else if (ack_i) begin
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : (dat_i & lane_mask(sel_q));
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    state_d     = RESP;
`ifdef WB_MASTER_RMW_EN
                    // The RMW write phase reports the old word captured by its read phase.
                    if (rmw_q && we_q) begin
                        rsp_dat_d = rsp_dat_q;
                    end
                    if (rd_phase_q) begin
                        cyc_d       = 1'b1;
                        rsp_valid_d = 1'b0;
                        rd_phase_d  = 1'b0;
                        we_d        = 1'b1;
                        sel_d       = '1;
                        dat_d       = (dat_i & ~lane_mask(wsel_q)) | (wdat_q & lane_mask(wsel_q));
                        state_d     = GAP;
                    end
`endif
                end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) begin
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`ifdef WB_MASTER_RMW_EN
            GAP: begin
                stb_d   = 1'b1;
                tmo_d   = '0;
                state_d = PHASE;
            end
`endif
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            tmo_q       <= '0;
`ifdef WB_MASTER_RMW_EN
            rmw_q       <= 1'b0;
            rd_phase_q  <= 1'b0;
            wdat_q      <= '0;
            wsel_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            tmo_q       <= tmo_d;
`ifdef WB_MASTER_RMW_EN
            rmw_q       <= rmw_d;
            rd_phase_q  <= rd_phase_d;
            wdat_q      <= wdat_d;
            wsel_q      <= wsel_d;
`endif
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_to_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
    assign sel_o         = sel_q;
    assign we_o          = we_q;
    assign stb_o         = stb_q;
    assign cyc_o         = cyc_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized bench for wb_master_bridge: a register-array slave with wait states, error and dead modes,
// checked against a command-level memory/response model.
module tb_wb_master_bridge;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int GR  = 8;
    localparam int SW  = DW / GR;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we, cmd_rmw;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_to;
    logic [DW-1:0] rsp_dat;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o, dat_i;
    logic [SW-1:0] sel_o;
    logic          we_o, stb_o, cyc_o, ack_i, err_i;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(GR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we), .cmd_rmw_i(cmd_rmw),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] s);
        logic [DW-1:0] m;
        for (int i = 0; i < SW; i++) m[i*GR +: GR] = {GR{s[i]}};
        return m;
    endfunction

    // Register-array slave: 16 words, ERR above, address 0x20 raises ACK and ERR together.
    logic [DW-1:0] smem [0:15];
    logic          s_ack = 1'b0, s_err = 1'b0, stray_ack = 1'b0;
    logic [DW-1:0] s_dat = '0;
    int            s_wcnt = 0;
    int            slave_wait = 0;
    bit            slave_dead = 1'b0;

    assign ack_i = s_ack | stray_ack;
    assign err_i = s_err;
    assign dat_i = s_dat;

    always @(posedge clk) begin
        if (s_ack || s_err) begin
            s_ack  <= 1'b0;
            s_err  <= 1'b0;
            s_wcnt <= 0;
        end else if (cyc_o && stb_o && !slave_dead) begin
            if (s_wcnt >= slave_wait) begin
                s_wcnt <= 0;
                if (adr_o < 16) begin
                    s_ack <= 1'b1;
                    if (we_o) begin
                        smem[adr_o[3:0]] <= (smem[adr_o[3:0]] & ~byte_mask(sel_o)) | (dat_o & byte_mask(sel_o));
                        s_dat <= $urandom;
                    end else begin
                        s_dat <= smem[adr_o[3:0]];
                    end
                end else if (adr_o == 16'h0020) begin
                    s_ack <= 1'b1;
                    s_err <= 1'b1;
                    s_dat <= $urandom;
                end else begin
                    s_err <= 1'b1;
                    s_dat <= $urandom;
                end
            end else begin
                s_wcnt <= s_wcnt + 1;
            end
        end else begin
            s_wcnt <= 0;
        end
    end

    int   stb_rises = 0, cyc_rises = 0, stb_hi = 0;
    logic stb_prev = 1'b0, cyc_prev = 1'b0;

    always @(negedge clk) begin
        if (stb_o && !stb_prev) stb_rises++;
        if (cyc_o && !cyc_prev) cyc_rises++;
        if (stb_o) stb_hi++;
        stb_prev = stb_o;
        cyc_prev = cyc_o;
    end

    // Reference model: word memory plus the expected response per command.
    logic [DW-1:0] mdl [0:15];

`ifdef WB_MASTER_RMW_EN
    localparam bit RMW_BUILT = 1'b1;
`else
    localparam bit RMW_BUILT = 1'b0;
`endif

    task automatic run_cmd(input logic we, input logic rmw, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                           input int wait_c, input bit dead, input int stall);
        logic [DW-1:0] e_dat;
        logic          e_err, e_to, eff_rmw;
        int            phases, e_lat, e_hi, n, lat;
        logic [DW+1:0] snap;

        eff_rmw = rmw && RMW_BUILT;
        e_dat = '0; e_err = 1'b0; e_to = 1'b0; phases = 1;
        if (dead) begin
            e_err = 1'b1; e_to = 1'b1;
        end else if (adr >= 16) begin
            e_err = 1'b1;
        end else if (eff_rmw) begin
            e_dat = mdl[adr[3:0]];
            mdl[adr[3:0]] = (mdl[adr[3:0]] & ~byte_mask(sel)) | (dat & byte_mask(sel));
            phases = 2;
        end else if (we) begin
            mdl[adr[3:0]] = (mdl[adr[3:0]] & ~byte_mask(sel)) | (dat & byte_mask(sel));
        end else begin
            e_dat = mdl[adr[3:0]] & byte_mask(sel);
        end
        e_lat = dead ? TMO : (phases == 2 ? 5 + 2 * wait_c : 2 + wait_c);
        e_hi  = dead ? TMO : phases * (2 + wait_c);

        slave_wait = wait_c;
        slave_dead = dead;
        cmd_we = we; cmd_rmw = rmw; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        stb_rises = 0; cyc_rises = 0; stb_hi = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we = $urandom; cmd_rmw = $urandom; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = $urandom;
        chk("cyc_stb_on_accept", {cyc_o, stb_o}, 2'b11);
        chk("bus_we_sel_adr", {we_o, sel_o, adr_o}, {eff_rmw ? 1'b0 : we, eff_rmw ? {SW{1'b1}} : sel, adr});
        if (!eff_rmw && we) chk("bus_dat", dat_o, dat);

        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("latency", lat, e_lat);
        chk("stb_high_cycles", stb_hi, e_hi);
        chk("phase_count", {stb_rises[7:0], cyc_rises[7:0]}, {phases[7:0], 8'd1});
        chk("bus_idle_in_resp", {cyc_o, stb_o, cmd_ready}, 3'b000);

        snap = {rsp_dat, rsp_err, rsp_to};
        for (int i = 0; i < stall; i++) begin
            stray_ack = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        stray_ack = 1'b0;
        if (stall > 0) chk("rsp_stable_stall", {rsp_valid, rsp_dat, rsp_err, rsp_to}, {1'b1, snap});

        chk("rsp_dat", rsp_dat, e_dat);
        chk("rsp_err_to", {rsp_err, rsp_to}, {e_err, e_to});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_rmw = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid, rsp_dat, rsp_err, rsp_to},
            '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_ready", cmd_ready, 1'b1);

        for (int a = 0; a < 16; a++) run_cmd(1'b1, 1'b0, AW'(a), $urandom, 4'hF, 0, 1'b0, 0);

        run_cmd(1'b1, 1'b0, 16'h0003, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
        run_cmd(1'b0, 1'b0, 16'h0003, 32'h0, 4'h3, 0, 1'b0, 0);
        run_cmd(1'b0, 1'b0, 16'h0100, 32'h0, 4'hF, 0, 1'b0, 0);
        run_cmd(1'b0, 1'b0, 16'h0020, 32'h0, 4'hF, 1, 1'b0, 0);
        run_cmd(1'b0, 1'b0, 16'h0005, 32'h0, 4'hF, 0, 1'b1, 0);
        run_cmd(1'b1, 1'b0, 16'h0006, 32'h12345678, 4'hF, 6, 1'b0, 0);
        run_cmd(1'b0, 1'b0, 16'h0006, 32'h0, 4'hC, 6, 1'b0, 0);

`ifdef WB_MASTER_RMW_EN
        run_cmd(1'b1, 1'b0, 16'h0002, 32'h11223344, 4'hF, 0, 1'b0, 0);
        run_cmd(1'b0, 1'b1, 16'h0002, 32'hAABBCCDD, 4'h2, 0, 1'b0, 0);
        chk("rmw_reg2", smem[2], 32'h1122CC44);
        run_cmd(1'b1, 1'b1, 16'h0100, 32'hAABBCCDD, 4'h2, 0, 1'b0, 0);
`endif

        run_cmd(1'b0, 1'b0, 16'h0003, 32'h0, 4'hF, 1, 1'b0, 5);
        cmd_we = 1'b0; cmd_rmw = 1'b0; cmd_adr = 16'h0004; cmd_sel = 4'hF;
        slave_wait = 5; slave_dead = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_phase_stb", stb_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid, rsp_dat, rsp_err, rsp_to}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("after_reset_quiet", {ack_i, err_i, rsp_valid, cyc_o, cmd_ready}, 5'b00001);

        for (int k = 0; k < 150; k++) begin
            logic [AW-1:0] a;
            int            r;
            r = $urandom_range(0, 19);
            a = (r == 0) ? 16'h0100 : (r == 1) ? 16'h0020 : AW'($urandom_range(0, 15));
            run_cmd(1'($urandom), 1'($urandom_range(0, 3) == 0), a, $urandom, SW'($urandom),
                    $urandom_range(0, 6), $urandom_range(0, 19) == 0, $urandom_range(0, 3));
        end

        for (int a = 0; a < 16; a++) chk($sformatf("mem_final_%0d", a), smem[a], mdl[a]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
